// File: rtl/ins_mem_pkg.sv
// Shared definitions for the instruction memory: bus widths, the NOP word
// and the fixed program image. Edit PROG_IMAGE to change the program.
package ins_mem_pkg;

  localparam int INS_DATA_W = 16;
  localparam int INS_ADDR_W = 16;
  localparam int INS_DEPTH  = 256;

  // Width of an index into the program image.
  localparam int IMAGE_IDX_W = 8;
  localparam int IMAGE_DEPTH = 1 << IMAGE_IDX_W;

  // Returned for empty and out-of-range locations.
  localparam logic [INS_DATA_W-1:0] INS_NOP = 16'h0000;

  // Fixed program image; any location not listed holds INS_NOP.
  localparam logic [INS_DATA_W-1:0] PROG_IMAGE [0:IMAGE_DEPTH-1] = '{
    2:       16'd18,
    4:       16'd112,
    6:       16'd144,
    8:       16'd160,
    10:      16'd194,
    12:      16'd128,
    default: INS_NOP
  };

endpackage

// File: rtl/ram_instruction.sv
// Read-only instruction memory. The read is combinational from ADDBUS.
// While RD is high the read word is also captured into hold_q on every
// rising clk edge; while RD is low DATAOUT replays hold_q, so the fetch
// stage never sees a floating or unknown word.
module ram_instruction
  import ins_mem_pkg::*;
#(
  parameter int DATA_W = INS_DATA_W,
  parameter int ADDR_W = INS_ADDR_W,
  parameter int DEPTH  = INS_DEPTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] ADDBUS,
  input  logic              RD,
  output logic [DATA_W-1:0] DATAOUT
);

  // ROM lookup. Addresses at or above DEPTH return NOP rather than
  // wrapping; the upper address bits only take part in that range check,
  // so they cannot select an image entry.
  function automatic logic [DATA_W-1:0] rom_read(input logic [ADDR_W-1:0] addr);
    logic [DATA_W-1:0] word;
    word = DATA_W'(INS_NOP);
    if ((32'(addr) < 32'(DEPTH)) && (32'(addr) < 32'(IMAGE_DEPTH))) begin
      word = DATA_W'(PROG_IMAGE[addr[IMAGE_IDX_W-1:0]]);
    end
    return word;
  endfunction

  logic [DATA_W-1:0] rd_word;
  logic [DATA_W-1:0] hold_q;

  // Combinational read of the current address; reset does not touch it.
  always_comb begin
    rd_word = rom_read(ADDBUS);
  end

  // Capture the read word on each edge with RD high; reset clears at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q <= '0;
    end else if (RD) begin
      hold_q <= rd_word;
    end
  end

  // Live word while reading, last captured word otherwise.
  always_comb begin
    DATAOUT = hold_q;
    if (RD) begin
      DATAOUT = rd_word;
    end
  end

endmodule

// File: tb/tb_ram_instruction.sv
// Directed bench for ram_instruction: reset, program image reads,
// unprogrammed and out-of-range addresses, hold behaviour and mid-run reset.
module tb_ram_instruction;

  localparam int W = 16;

  logic          clk;
  logic          rst_n;
  logic [15:0]   addbus;
  logic          rd;
  logic [W-1:0]  dataout;

  int checks   = 0;
  int failures = 0;

  logic [W-1:0] exp_q[$];

  ram_instruction dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ADDBUS  (addbus),
    .RD      (rd),
    .DATAOUT (dataout)
  );

  // Clock / reset block: 100-unit period, inputs idle low.
  initial begin
    clk = 1'b0;
    forever #50 clk = ~clk;
  end

  initial begin
    rst_n  = 1'b0;
    rd     = 1'b0;
    addbus = '0;
  end

  task automatic test_reset();
    logic [W-1:0] exp;
    exp = 16'd0;
    @(negedge clk);
    rst_n = 1'b0; rd = 1'b0; addbus = 16'd0;
    #20;
    checks++;
    if (dataout !== exp) begin
      failures++;
      $display("FAIL reset_held got=%0d want=%0d", dataout, exp);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #20;
    checks++;
    if (dataout !== exp) begin
      failures++;
      $display("FAIL reset_released got=%0d want=%0d", dataout, exp);
    end
  endtask

  task automatic test_program_image();
    logic [15:0]  addrs [6];
    logic [W-1:0] want;
    addrs = '{16'd2, 16'd4, 16'd6, 16'd8, 16'd10, 16'd12};
    exp_q.push_back(16'd18);
    exp_q.push_back(16'd112);
    exp_q.push_back(16'd144);
    exp_q.push_back(16'd160);
    exp_q.push_back(16'd194);
    exp_q.push_back(16'd128);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      rd = 1'b1; addbus = addrs[i];
      #20;
      want = exp_q.pop_front();
      checks++;
      if (dataout !== want) begin
        failures++;
        $display("FAIL image_read addr=%0d got=%0d want=%0d", addrs[i], dataout, want);
      end
    end
  endtask

  task automatic test_unprogrammed();
    logic [15:0] addrs [3];
    addrs = '{16'd3, 16'd0, 16'd255};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      rd = 1'b1; addbus = addrs[i];
      #20;
      checks++;
      if (dataout !== 16'd0) begin
        failures++;
        $display("FAIL unprogrammed addr=%0d got=%0d want=0", addrs[i], dataout);
      end
    end
  endtask

  task automatic test_hold();
    @(negedge clk);
    rd = 1'b1; addbus = 16'd10;
    @(negedge clk);            // one rising edge has latched 194
    rd = 1'b0; addbus = 16'd4;
    #20;
    checks++;
    if (dataout !== 16'd194) begin
      failures++;
      $display("FAIL hold_after_rd_low got=%0d want=194", dataout);
    end
    @(negedge clk);            // an edge with RD low must not reload
    #20;
    checks++;
    if (dataout !== 16'd194) begin
      failures++;
      $display("FAIL hold_across_edge got=%0d want=194", dataout);
    end
    rd = 1'b1;
    #1;
    checks++;
    if (dataout !== 16'd112) begin
      failures++;
      $display("FAIL rd_rise_immediate got=%0d want=112", dataout);
    end
    @(negedge clk);            // hold now 112
  endtask

  task automatic test_out_of_range();
    rd = 1'b1; addbus = 16'hFFFF;
    #20;
    checks++;
    if (dataout !== 16'd0) begin
      failures++;
      $display("FAIL oor_ffff got=%0d want=0", dataout);
    end
    addbus = 16'd258;          // would alias to mem[2]=18 if it wrapped
    #1;
    checks++;
    if (dataout !== 16'd0) begin
      failures++;
      $display("FAIL oor_no_wrap got=%0d want=0", dataout);
    end
    addbus = 16'd256;
    @(negedge clk);            // edge latches 0 over the earlier 112
    rd = 1'b0;
    #20;
    checks++;
    if (dataout !== 16'd0) begin
      failures++;
      $display("FAIL oor_held got=%0d want=0", dataout);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    rd = 1'b1; addbus = 16'd8;
    @(negedge clk);            // hold = 160
    rd = 1'b0; addbus = 16'd0;
    #10;
    checks++;
    if (dataout !== 16'd160) begin
      failures++;
      $display("FAIL pre_reset_hold got=%0d want=160", dataout);
    end
    #10;
    rst_n = 1'b0;
    #1;
    checks++;
    if (dataout !== 16'd0) begin
      failures++;
      $display("FAIL async_reset_clear got=%0d want=0", dataout);
    end
    rd = 1'b1; addbus = 16'd6;
    #1;
    checks++;
    if (dataout !== 16'd144) begin
      failures++;
      $display("FAIL read_during_reset got=%0d want=144", dataout);
    end
    rd = 1'b0;
    #1;
    checks++;
    if (dataout !== 16'd0) begin
      failures++;
      $display("FAIL hold_in_reset got=%0d want=0", dataout);
    end
    #5;
    rst_n = 1'b1;
    rd = 1'b1; addbus = 16'd8;
    #1;
    checks++;
    if (dataout !== 16'd160) begin
      failures++;
      $display("FAIL read_after_release got=%0d want=160", dataout);
    end
    @(negedge clk);            // first edge after release loads 160
    rd = 1'b0; addbus = 16'd2;
    #1;
    checks++;
    if (dataout !== 16'd160) begin
      failures++;
      $display("FAIL load_after_release got=%0d want=160", dataout);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] addrs [4];
    addrs = '{16'd12, 16'd2, 16'd6, 16'd4};
    exp_q.push_back(16'd128);
    exp_q.push_back(16'd18);
    exp_q.push_back(16'd144);
    exp_q.push_back(16'd112);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      rd = 1'b1; addbus = addrs[i];
    end
    @(negedge clk);            // last edge latched mem[4]
    rd = 1'b0; addbus = 16'd12;
    for (int i = 0; i < 3; i++) void'(exp_q.pop_front());
    #20;
    checks++;
    if (dataout !== exp_q[0]) begin
      failures++;
      $display("FAIL back_to_back_hold got=%0d want=%0d", dataout, exp_q[0]);
    end
    void'(exp_q.pop_front());
  endtask

  initial begin
    #1;
    test_reset();
    test_program_image();
    test_unprogrammed();
    test_hold();
    test_out_of_range();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
